shell_manager: RTL
==================

SHELL_MANAGER -- requirements
Module: shell_manager

Interface
REQ-001 SHALL have parameter MAP_W, default 40, playfield width in grid cells.
REQ-002 SHALL have parameter MAP_H, default 30, playfield height in grid cells.
REQ-003 SHALL have parameter COOLDOWN, default 8, ticks between accepted fires (used only with SHELL_COOLDOWN_EN).
REQ-004 SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_clear, input, 1: synchronous game-restart clear.
REQ-007 SHALL have port i_tick, input, 1: one-cycle game-step pulse.
REQ-008 SHALL have port i_fire, input, 1: fire request, level.
REQ-009 SHALL have ports i_tank_x / i_tank_y, input, 6 each: owning tank grid position.
REQ-010 SHALL have port i_tank_dir, input, 2: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1).
REQ-011 SHALL have port i_hit, input, 5: per-slot kill from external collision logic.
REQ-012 SHALL have ports o_shell_0_x..o_shell_4_x / o_shell_0_y..o_shell_4_y, output, 6 each: shell grid positions.
REQ-013 SHALL have port o_shell_valid, output, 5: per-slot live flag.
REQ-014 SHALL have port o_fire_ack, output, 1: one-cycle pulse on accepted fire.

Function
REQ-015 SHALL hold per slot: x, y, 2-bit dir, valid; all outputs registered.
REQ-016 SHALL, on i_tick, move each valid slot one cell along its stored dir.
REQ-017 SHALL clear valid instead of moving when the move would leave 0..MAP_W-1 / 0..MAP_H-1 (x==0 left, x==MAP_W-1 right, y==0 up, y==MAP_H-1 down).
REQ-018 SHALL clear valid of slot k the cycle after i_hit[k]=1 with that slot valid; hit overrides a same-cycle move.
REQ-019 SHALL ignore i_hit[k] for an invalid slot.
REQ-020 SHALL accept a fire when i_fire=1, a free slot exists, the spawn cell (tank position + one cell along i_tank_dir) is in bounds, and the cooldown gate (REQ-032) is open.
REQ-021 SHALL allocate the lowest-indexed invalid slot, writing spawn x/y, dir=i_tank_dir, valid=1 at the next edge.
REQ-022 SHALL pulse o_fire_ack for exactly one cycle, same edge as the spawn write; latency i_fire -> valid/ack = 1 cycle.
REQ-023 SHALL reject fire with no ack and no state change when all five slots valid or spawn cell out of bounds.
REQ-024 SHALL re-accept a held i_fire each cycle once conditions allow (no edge detect); caller deasserts after ack.
REQ-025 SHALL not move a shell on the cycle it spawns, even with coincident i_tick.
REQ-026 SHALL allow a slot freed by hit/out-of-bounds on cycle N to be reallocated no earlier than cycle N+1.
REQ-027 SHALL, on i_clear, clear all valid bits, ack, and cooldown next edge; i_clear overrides fire, tick, hit.
REQ-028 SHALL compute moves in 7-bit arithmetic so no wrap-around produces a valid in-bounds coordinate.

Reset
REQ-029 SHALL, while i_rst_n=0, asynchronously force all x/y=0, dir=0, o_shell_valid=0, o_fire_ack=0, cooldown=0.
REQ-030 SHALL discard any in-flight fire or movement on reset; first action possible on first edge after release.

Configuration
REQ-031 SHALL use macro SHELL_COOLDOWN_EN to compile the fire cooldown in or out.
REQ-032 SHALL, with SHELL_COOLDOWN_EN defined, load a counter with COOLDOWN on each accepted fire, decrement on each i_tick down to 0, and gate acceptance on counter==0.
REQ-033 SHALL, without SHELL_COOLDOWN_EN, omit the counter; acceptance depends only on free slot and spawn bounds.

Verification
REQ-034 SHALL cover: reset release, tank (5,5) dir=1, i_fire 1 cycle -> next cycle slot0 (6,5) valid=00001, ack pulse 1 cycle.
REQ-035 SHALL cover: shell at (39,7) dir=1, i_tick -> valid[k]=0; shell at (0,3) dir=3, i_tick -> valid[k]=0.
REQ-036 SHALL cover: slots 0-4 valid, i_fire held -> no ack; i_hit[2] -> next fire fills slot 2, ack one cycle after slot frees.
REQ-037 SHALL cover: i_hit[1] and i_tick same cycle on shell (10,10) -> valid[1]=0, position not required.
REQ-038 SHALL cover: SHELL_COOLDOWN_EN, COOLDOWN=8, i_fire held -> second ack only after 8 ticks; without macro -> acks on consecutive cycles until 5 slots full.
REQ-039 SHALL cover: i_rst_n low mid-flight with 3 valid shells -> valid=0 immediately, no ack after release until new fire.

Source files
------------

// File: rtl/shell_manager.sv
// Five-slot tank shell manager: spawns, advances, and retires shells on a MAP_W x MAP_H grid.
// Optional fire cooldown compiled in with `define SHELL_COOLDOWN_EN.
module shell_manager #(
   parameter int MAP_W    = 40,
   parameter int MAP_H    = 30,
   parameter int COOLDOWN = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clear,
   input  logic       i_tick,
   input  logic       i_fire,
   input  logic [5:0] i_tank_x,
   input  logic [5:0] i_tank_y,
   input  logic [1:0] i_tank_dir,
   input  logic [4:0] i_hit,
   output logic [5:0] o_shell_0_x,
   output logic [5:0] o_shell_1_x,
   output logic [5:0] o_shell_2_x,
   output logic [5:0] o_shell_3_x,
   output logic [5:0] o_shell_4_x,
   output logic [5:0] o_shell_0_y,
   output logic [5:0] o_shell_1_y,
   output logic [5:0] o_shell_2_y,
   output logic [5:0] o_shell_3_y,
   output logic [5:0] o_shell_4_y,
   output logic [4:0] o_shell_valid,
   output logic       o_fire_ack
);

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_e;

   typedef struct packed {
      logic       ok;
      logic [5:0] x;
      logic [5:0] y;
   } cell_t;

   localparam logic [6:0] MAX_X = 7'(MAP_W - 1);
   localparam logic [6:0] MAX_Y = 7'(MAP_H - 1);

   if (COOLDOWN < 1) begin : g_cooldown_range
      $error("shell_manager: COOLDOWN must be at least 1");
   end

   // 7-bit step: 0-1 becomes 127, which always fails the upper-bound test.
   function automatic cell_t step_cell(input logic [5:0] x, input logic [5:0] y, input dir_e d);
      logic [6:0] nx;
      logic [6:0] ny;
      cell_t      c;
      nx = {1'b0, x};
      ny = {1'b0, y};
      case (d)
         DIR_UP:    ny = ny - 7'd1;
         DIR_RIGHT: nx = nx + 7'd1;
         DIR_DOWN:  ny = ny + 7'd1;
         DIR_LEFT:  nx = nx - 7'd1;
      endcase
      c.ok = (nx <= MAX_X) && (ny <= MAX_Y);
      c.x  = nx[5:0];
      c.y  = ny[5:0];
      return c;
   endfunction

   logic [5:0] pos_x [5];
   logic [5:0] pos_y [5];
   dir_e       dir_q [5];
   logic [4:0] valid_q;
   logic       ack_q;

   cell_t      spawn;
   cell_t      mv [5];
   logic       has_free;
   logic [2:0] alloc_idx;
   logic       cd_open;
   logic       accept;

   always_comb begin
      spawn     = step_cell(i_tank_x, i_tank_y, dir_e'(i_tank_dir));
      has_free  = 1'b0;
      alloc_idx = '0;
      for (int unsigned k = 0; k < 5; k++) begin
         mv[k] = step_cell(pos_x[k], pos_y[k], dir_q[k]);
         if (!valid_q[k] && !has_free) begin
            has_free  = 1'b1;
            alloc_idx = 3'(k);
         end
      end
   end

   assign accept = i_fire && has_free && spawn.ok && cd_open && !i_clear;

`ifdef SHELL_COOLDOWN_EN
   localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
   logic [CD_W-1:0] cd_q;

   assign cd_open = (cd_q == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cd_q <= '0;
      else if (i_clear)
         cd_q <= '0;
      else if (accept)
         cd_q <= CD_W'(COOLDOWN);
      else if (i_tick && cd_q != '0)
         cd_q <= cd_q - 1'b1;
   end
`else
   assign cd_open = 1'b1;
`endif

   // Per slot: clear > spawn (slot is free, so no move/hit applies) > hit > tick move.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         ack_q   <= 1'b0;
         for (int unsigned k = 0; k < 5; k++) begin
            pos_x[k] <= '0;
            pos_y[k] <= '0;
            dir_q[k] <= DIR_UP;
         end
      end else begin
         ack_q <= accept;
         for (int unsigned k = 0; k < 5; k++) begin
            if (i_clear) begin
               valid_q[k] <= 1'b0;
            end else if (accept && alloc_idx == 3'(k)) begin
               pos_x[k]   <= spawn.x;
               pos_y[k]   <= spawn.y;
               dir_q[k]   <= dir_e'(i_tank_dir);
               valid_q[k] <= 1'b1;
            end else if (valid_q[k]) begin
               if (i_hit[k]) begin
                  valid_q[k] <= 1'b0;
               end else if (i_tick) begin
                  if (mv[k].ok) begin
                     pos_x[k] <= mv[k].x;
                     pos_y[k] <= mv[k].y;
                  end else begin
                     valid_q[k] <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign o_shell_0_x   = pos_x[0];
   assign o_shell_1_x   = pos_x[1];
   assign o_shell_2_x   = pos_x[2];
   assign o_shell_3_x   = pos_x[3];
   assign o_shell_4_x   = pos_x[4];
   assign o_shell_0_y   = pos_y[0];
   assign o_shell_1_y   = pos_y[1];
   assign o_shell_2_y   = pos_y[2];
   assign o_shell_3_y   = pos_y[3];
   assign o_shell_4_y   = pos_y[4];
   assign o_shell_valid = valid_q;
   assign o_fire_ack    = ack_q;

endmodule
